execute_cycle: RTL and testbench
================================

EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have parameter none; widths fixed: XLEN 32, register index 5, ALU control 3.
REQ-002 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-003 SHALL have inputs RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, FlushE (1 each); ALUControlE (3); RD_E (5); RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW (32); ForwardA_E, ForwardB_E (2).
REQ-004 SHALL have outputs: PCSrcE (1), PCTargetE (32), StallE (1), all combinational.
REQ-005 SHALL have registered outputs: RegWriteM, MemWriteM, ResultSrcM (1); RD_M (5); PCPlus4M, WriteDataM, ALU_ResultM (32).

Function
REQ-006 SHALL select SrcA: ForwardA_E 00 RD1_E, 01 ResultW, 10 ALU_ResultM, 11 RD1_E.
REQ-007 SHALL select forwarded B (same encoding on RD2_E); WriteData = forwarded B; SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
REQ-008 SHALL decode ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 signed slt (result 0/1), 100 mul (low 32 bits), others result 0; add/sub wrap modulo 2^32.
REQ-009 SHALL drive ZeroE = (ALU result == 0); PCTargetE = PCE + Imm_Ext_E modulo 2^32.
REQ-010 SHALL drive PCSrcE = BranchE & ZeroE & ~FlushE & ~StallE.
REQ-011 Non-mul ops SHALL have 1-cycle latency: all M outputs load at next clk edge.
REQ-012 Mul FSM states IDLE, BUSY, DONE; reset to IDLE.
REQ-013 IDLE with ALUControlE==100 and FlushE=0: latch SrcA, SrcB, RD_E, RegWriteE, ResultSrcE, PCPlus4E; clear product and 5-bit count; go BUSY.
REQ-014 BUSY: one shift-add step per cycle on latched operands; after step with count 31 go DONE (exactly 32 BUSY cycles).
REQ-015 DONE: M registers load product and latched control; MemWriteM 0; go IDLE; same-cycle mul op SHALL NOT restart.
REQ-016 StallE SHALL be 1 in IDLE-with-mul-detect cycle and all BUSY cycles, 0 in DONE; total 33 stall cycles per mul.
REQ-017 While StallE=1, M registers SHALL load bubble: RegWriteM, MemWriteM, ResultSrcM 0, RD_M 0, data 0.
REQ-018 FlushE=1 SHALL load bubble into M next edge; in BUSY or DONE it aborts the mul, returns IDLE, drops result.
REQ-019 Latched operands SHALL be immune to ResultW/ALU_ResultM changes during BUSY.

Reset
REQ-020 rst=1 at clk edge SHALL force FSM IDLE, count 0, product 0, all M outputs 0; overrides FlushE and mid-mul state.
REQ-021 During rst=1, StallE SHALL be 0 and PCSrcE per REQ-010 combinationally.

Configuration
REQ-022 Macro EXEC_MUL_EN defined: mul FSM, StallE logic per REQ-012..019 compiled in.
REQ-023 EXEC_MUL_EN undefined: no FSM/multiplier; ALUControlE 100 yields result 0 with 1-cycle latency; StallE tied 0.

Structure
REQ-024 Shared package riscv_pkg SHALL hold ALU op encodings, forward-select encodings, FSM state typedef, XLEN constant.
REQ-025 Combinational ALU SHALL be sub-module alu (ops 000-011, 101; ZeroE); mul FSM and pipeline register in execute_cycle.

Verification
REQ-026 RD1_E=5, RD2_E=7, ALUControlE=000, ALUSrcE=0, fwd 00 -> next edge ALU_ResultM=12, WriteDataM=7.
REQ-027 ForwardA_E=01, ResultW=0xFFFFFFFF, Imm=1, ALUSrcE=1, add -> ALU_ResultM=0 (wrap); BranchE=1, sub 3-3, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120.
REQ-028 EXEC_MUL_EN, mul 6*7, RD_E=3, RegWriteE=1 -> StallE high 33 cycles, bubbles in M, then ALU_ResultM=42, RD_M=3, RegWriteM=1 once.
REQ-029 Mul 0x10000*0x10000 -> ALU_ResultM=0; slt -1 vs 1 -> 1.
REQ-030 FlushE=1 at BUSY cycle 10 -> StallE 0 next cycle, no RegWriteM pulse; rst=1 mid-BUSY -> all outputs 0, IDLE.
REQ-031 Build without EXEC_MUL_EN, mul 6*7 -> StallE never 1, ALU_ResultM=0 after 1 cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared XLEN, ALU op codes, forward selects and multiplier FSM states.
package riscv_pkg;
    localparam int XLEN = 32;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;
    typedef logic [1:0] mul_state_t;
    localparam mul_state_t IDLE = 2'd0;
    localparam mul_state_t BUSY = 2'd1;
    localparam mul_state_t DONE = 2'd2;
endpackage

// File: rtl/execute_cycle_if.sv
// execute_cycle_if: EX-stage inputs plus the branch, stall and EX/MEM register outputs.
interface execute_cycle_if;
    import riscv_pkg::*;
    logic            RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, FlushE;
    logic [2:0]      ALUControlE;
    logic [4:0]      RD_E;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [1:0]      ForwardA_E, ForwardB_E;
    logic            PCSrcE, StallE;
    logic [XLEN-1:0] PCTargetE;
    logic            RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;
    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, FlushE, ALUControlE, RD_E,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
        output PCSrcE, StallE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );
    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, FlushE, ALUControlE, RD_E,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
        input  PCSrcE, StallE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/alu.sv
// alu: combinational add/sub/and/or/signed-slt; every other code yields 0.
module alu
    import riscv_pkg::*;
(
    input  logic [2:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    always_comb begin
        result = ctrl == ALU_ADD ? a + b :
                 ctrl == ALU_SUB ? a - b :
                 ctrl == ALU_AND ? a & b :
                 ctrl == ALU_OR  ? a | b :
                 ctrl == ALU_SLT ? XLEN'($signed(a) < $signed(b)) : '0;
        zero = result == '0;
    end
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage with operand forwarding, branch resolve and EX/MEM register.
// Define EXEC_MUL_EN to add a 32-step shift-add multiplier that stalls the pipe.
module execute_cycle
    import riscv_pkg::*;
(
    input logic            clk,
    input logic            rst,
    execute_cycle_if.slave bus
);
    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, product, pc4_lat;
    logic [4:0]      rd_lat;
    logic            zero, stall, mul_done, rw_lat, rs_lat;
    always_comb begin
        src_a = bus.ForwardA_E == FWD_WB  ? bus.ResultW :
                bus.ForwardA_E == FWD_MEM ? bus.ALU_ResultM : bus.RD1_E;
        fwd_b = bus.ForwardB_E == FWD_WB  ? bus.ResultW :
                bus.ForwardB_E == FWD_MEM ? bus.ALU_ResultM : bus.RD2_E;
        src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
    end
    alu u_alu (.ctrl(bus.ALUControlE), .a(src_a), .b(src_b), .result(alu_result), .zero(zero));
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
    assign bus.PCSrcE    = bus.BranchE & zero & ~bus.FlushE & ~stall;
    assign bus.StallE    = stall;
`ifdef EXEC_MUL_EN
    mul_state_t      state;
    logic [4:0]      count;
    logic [XLEN-1:0] a_lat, b_lat;
    logic            mul_start;
    assign mul_start = state == IDLE && bus.ALUControlE == ALU_MUL && !bus.FlushE;
    assign stall     = !rst && (mul_start || state == BUSY);
    assign mul_done  = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            product <= '0;
        end else if (bus.FlushE && state != IDLE) begin
            state <= IDLE;
        end else if (mul_start) begin
            state   <= BUSY;
            count   <= '0;
            product <= '0;
        end else if (state == BUSY) begin
            product <= product + (b_lat[count] ? a_lat << count : '0);
            count   <= count + 5'd1;
            if (count == 5'd31) state <= DONE;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
    // Operands are captured once so later forwarding changes cannot disturb the product
    always_ff @(posedge clk) begin
        if (mul_start) begin
            a_lat   <= src_a;
            b_lat   <= src_b;
            rd_lat  <= bus.RD_E;
            rw_lat  <= bus.RegWriteE;
            rs_lat  <= bus.ResultSrcE;
            pc4_lat <= bus.PCPlus4E;
        end
    end
`else
    assign stall    = 1'b0;
    assign mul_done = 1'b0;
    assign product  = '0;
    assign pc4_lat  = '0;
    assign rd_lat   = '0;
    assign rw_lat   = 1'b0;
    assign rs_lat   = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst || bus.FlushE || stall) begin
            bus.RegWriteM   <= 1'b0;
            bus.MemWriteM   <= 1'b0;
            bus.ResultSrcM  <= 1'b0;
            bus.RD_M        <= '0;
            bus.PCPlus4M    <= '0;
            bus.WriteDataM  <= '0;
            bus.ALU_ResultM <= '0;
        end else if (mul_done) begin
            bus.RegWriteM   <= rw_lat;
            bus.MemWriteM   <= 1'b0;
            bus.ResultSrcM  <= rs_lat;
            bus.RD_M        <= rd_lat;
            bus.PCPlus4M    <= pc4_lat;
            bus.WriteDataM  <= '0;
            bus.ALU_ResultM <= product;
        end else begin
            bus.RegWriteM   <= bus.RegWriteE;
            bus.MemWriteM   <= bus.MemWriteE;
            bus.ResultSrcM  <= bus.ResultSrcE;
            bus.RD_M        <= bus.RD_E;
            bus.PCPlus4M    <= bus.PCPlus4E;
            bus.WriteDataM  <= fwd_b;
            bus.ALU_ResultM <= alu_result;
        end
    end
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: vector table, multiplier sequences and a random run against a reference model.
module tb_execute_cycle;
    logic clk, rst;
    int passed, total;
    logic [31:0] exp_m;
    execute_cycle_if bus ();
    execute_cycle dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  fa, fb;
        logic        src, br;
        logic [31:0] rd1, rd2, imm, rw, pce;
        logic [31:0] e_alu, e_wd;
        logic        e_pcsrc;
        logic [31:0] e_tgt;
    } vec_t;
    vec_t tv[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic chk_m(input logic rw, mw, rs, input logic [4:0] rd, input logic [31:0] pc4, wd, res);
        chk("RegWriteM", bus.RegWriteM, rw);
        chk("MemWriteM", bus.MemWriteM, mw);
        chk("ResultSrcM", bus.ResultSrcM, rs);
        chk("RD_M", bus.RD_M, rd);
        chk("PCPlus4M", bus.PCPlus4M, pc4);
        chk("WriteDataM", bus.WriteDataM, wd);
        chk("ALU_ResultM", bus.ALU_ResultM, res);
    endtask

    task automatic set_nop();
        bus.ALUControlE = 3'b000; bus.ForwardA_E = 2'b00; bus.ForwardB_E = 2'b00;
        bus.ALUSrcE = 1'b0; bus.BranchE = 1'b0; bus.FlushE = 1'b0;
        bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b0; bus.ResultSrcE = 1'b0; bus.RD_E = '0;
        bus.RD1_E = '0; bus.RD2_E = '0; bus.Imm_Ext_E = '0; bus.PCE = '0; bus.PCPlus4E = '0;
        bus.ResultW = '0;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r, w, m);
        return sel == 2'b01 ? w : sel == 2'b10 ? m : r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, b);
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

`ifdef EXEC_MUL_EN
    task automatic do_mul(input logic [31:0] a, b, input logic [4:0] rd, input bit noisy);
        int st, bad;
        logic [63:0] full;
        st = 0; bad = 0;
        full = 64'(a) * 64'(b);
        set_nop();
        bus.ALUControlE = 3'b100; bus.ForwardA_E = noisy ? 2'b01 : 2'b00;
        bus.ResultW = a; bus.RD1_E = noisy ? $urandom : a; bus.RD2_E = b;
        bus.RD_E = rd; bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.PCPlus4E = 32'h44;
        #1;
        while (bus.StallE === 1'b1 && st < 40) begin
            st++;
            @(posedge clk); #1;
            if (noisy) bus.ResultW = $urandom;
            if (bus.RegWriteM !== 1'b0 || bus.ALU_ResultM !== 32'd0 || bus.RD_M !== 5'd0) bad++;
            #1;
        end
        chk("mul stall cycles", st, 33);
        chk("mul bubbles", bad, 0);
        @(posedge clk); #1;
        set_nop();
        #1;
        chk_m(1'b1, 1'b0, 1'b0, rd, 32'h44, 32'd0, full[31:0]);
        chk("StallE after mul", bus.StallE, 1'b0);
        @(posedge clk); #1;
        chk("RegWriteM single pulse", bus.RegWriteM, 1'b0);
        exp_m = 32'd0;
    endtask
`endif

    initial begin
        passed = 0; total = 0;
        rst = 1'b1;
        set_nop();
        bus.BranchE = 1'b1; bus.ALUControlE = 3'b001; bus.RD1_E = 32'd3; bus.RD2_E = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        chk_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        chk("StallE in reset", bus.StallE, 1'b0);
        chk("PCSrcE in reset", bus.PCSrcE, 1'b1);
        set_nop();
        rst = 1'b0;

        tv.push_back(vec_t'{3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 32'd12, 32'd7, 1'b0, 32'd0});
        tv.push_back(vec_t'{3'b000, 2'b01, 2'b00, 1'b1, 1'b0, 32'd0, 32'd9, 32'd1, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd9, 1'b0, 32'd5});
        tv.push_back(vec_t'{3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 32'd3, 32'd3, 32'h20, 32'd0, 32'h100, 32'd0, 32'd3, 1'b1, 32'h120});
        tv.push_back(vec_t'{3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 1'b0, 32'd0});
        tv.push_back(vec_t'{3'b101, 2'b00, 2'b00, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd0});
        tv.push_back(vec_t'{3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'd8, 32'h00F0, 32'h0FF0, 1'b0, 32'd8});
        tv.push_back(vec_t'{3'b011, 2'b00, 2'b00, 1'b0, 1'b1, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'd8, 32'hFFF0, 32'h0FF0, 1'b0, 32'd8});
        tv.push_back(vec_t'{3'b001, 2'b00, 2'b00, 1'b0, 1'b1, 32'd0, 32'd1, 32'd0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFF0});
        tv.push_back(vec_t'{3'b110, 2'b00, 2'b00, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd6, 1'b0, 32'd0});
        tv.push_back(vec_t'{3'b111, 2'b00, 2'b00, 1'b0, 1'b1, 32'd5, 32'd6, 32'hFFFFFFFF, 32'd0, 32'd2, 32'd0, 32'd6, 1'b1, 32'd1});
        tv.push_back(vec_t'{3'b000, 2'b11, 2'b11, 1'b0, 1'b0, 32'd2, 32'hA, 32'd0, 32'd0, 32'd0, 32'hC, 32'hA, 1'b0, 32'd0});
        tv.push_back(vec_t'{3'b000, 2'b00, 2'b01, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, 32'h55, 32'd0, 32'h56, 32'h55, 1'b0, 32'd0});
`ifndef EXEC_MUL_EN
        tv.push_back(vec_t'{3'b100, 2'b00, 2'b00, 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 1'b0, 32'd0});
`endif
        foreach (tv[i]) begin
            bus.ALUControlE = tv[i].op; bus.ForwardA_E = tv[i].fa; bus.ForwardB_E = tv[i].fb;
            bus.ALUSrcE = tv[i].src; bus.BranchE = tv[i].br; bus.RD1_E = tv[i].rd1;
            bus.RD2_E = tv[i].rd2; bus.Imm_Ext_E = tv[i].imm; bus.ResultW = tv[i].rw;
            bus.PCE = tv[i].pce; bus.PCPlus4E = tv[i].pce + 32'd4; bus.RD_E = 5'(i + 1);
            bus.RegWriteE = 1'b1; bus.MemWriteE = i[0]; bus.ResultSrcE = i[1]; bus.FlushE = 1'b0;
            #1;
            chk("vec PCSrcE", bus.PCSrcE, tv[i].e_pcsrc);
            chk("vec PCTargetE", bus.PCTargetE, tv[i].e_tgt);
            chk("vec StallE", bus.StallE, 1'b0);
            @(posedge clk); #1;
            chk_m(1'b1, i[0], i[1], 5'(i + 1), tv[i].pce + 32'd4, tv[i].e_wd, tv[i].e_alu);
            exp_m = tv[i].e_alu;
        end

`ifdef EXEC_MUL_EN
        do_mul(32'd6, 32'd7, 5'd3, 1'b0);
        do_mul(32'h10000, 32'h10000, 5'd9, 1'b0);
        do_mul(32'd6, 32'd7, 5'd4, 1'b1);
        do_mul(32'hDEADBEEF, 32'h12345679, 5'd31, 1'b0);
        begin
            int bad;
            bad = 0;
            set_nop();
            bus.ALUControlE = 3'b100; bus.RD1_E = 32'd6; bus.RD2_E = 32'd7;
            bus.RD_E = 5'd3; bus.RegWriteE = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            bus.FlushE = 1'b1;
            @(posedge clk); #1;
            set_nop();
            #1;
            chk("flush StallE", bus.StallE, 1'b0);
            chk("flush RegWriteM", bus.RegWriteM, 1'b0);
            repeat (40) begin
                @(posedge clk); #1;
                if (bus.RegWriteM !== 1'b0 || bus.StallE !== 1'b0) bad++;
            end
            chk("flush no pulse", bad, 0);
            bus.ALUControlE = 3'b100; bus.RD1_E = 32'd6; bus.RD2_E = 32'd7;
            bus.RD_E = 5'd3; bus.RegWriteE = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk("rst StallE", bus.StallE, 1'b0);
            @(posedge clk); #1;
            chk_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
            set_nop();
            rst = 1'b0;
            #1;
            chk("post rst StallE", bus.StallE, 1'b0);
            @(posedge clk); #1;
            exp_m = 32'd0;
        end
        do_mul(32'd3, 32'd5, 5'd7, 1'b0);
`endif

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, b, sb, res;
            logic [2:0] op;
            logic flush, pcs;
            op = 3'($urandom_range(0, 7));
`ifdef EXEC_MUL_EN
            if (op == 3'b100) op = 3'b001;
`endif
            bus.ALUControlE = op;
            bus.ForwardA_E = 2'($urandom_range(0, 3));
            bus.ForwardB_E = 2'($urandom_range(0, 3));
            bus.ALUSrcE = 1'($urandom_range(0, 1));
            bus.BranchE = 1'($urandom_range(0, 1));
            bus.RD1_E = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.RD2_E = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.Imm_Ext_E = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.ResultW = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.PCE = $urandom; bus.PCPlus4E = $urandom; bus.RD_E = 5'($urandom);
            bus.RegWriteE = 1'($urandom); bus.MemWriteE = 1'($urandom); bus.ResultSrcE = 1'($urandom);
            flush = $urandom_range(0, 7) == 0;
            bus.FlushE = flush;
            a = pick(bus.ForwardA_E, bus.RD1_E, bus.ResultW, exp_m);
            b = pick(bus.ForwardB_E, bus.RD2_E, bus.ResultW, exp_m);
            sb = bus.ALUSrcE ? bus.Imm_Ext_E : b;
            res = ref_alu(op, a, sb);
            pcs = bus.BranchE && res == 32'd0 && !flush;
            #1;
            chk("rnd PCSrcE", bus.PCSrcE, pcs);
            chk("rnd PCTargetE", bus.PCTargetE, bus.PCE + bus.Imm_Ext_E);
            chk("rnd StallE", bus.StallE, 1'b0);
            @(posedge clk); #1;
            if (flush) begin
                chk_m(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
                exp_m = 32'd0;
            end else begin
                chk_m(bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.RD_E, bus.PCPlus4E, b, res);
                exp_m = res;
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
